// File: rtl/mips_processor_top.sv
// Single-cycle mini-MIPS core with integrated instruction/data memories, a 32x32 integer
// register file, a 32x32 single-precision FP register file and an FP condition flag.
// Memories are filled through the external write ports; the core executes from word 0.
module mips_processor_top #(
   parameter int unsigned MEM_DEPTH = 1024,
   parameter int unsigned XLEN      = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [XLEN-1:0]              instr,
   input  logic [$clog2(MEM_DEPTH)-1:0] instr_addr,
   input  logic                         ins_we,
   input  logic [XLEN-1:0]              data,
   input  logic [$clog2(MEM_DEPTH)-1:0] data_addr,
   input  logic                         data_we,
   output logic [XLEN-1:0]              processor_out,
   output logic                         done
);

   localparam int unsigned AW = $clog2(MEM_DEPTH);
   localparam logic [AW-1:0] PcOne = AW'(1);

   typedef logic [XLEN-1:0] word_t;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpMfc1  = 6'b011000;
   localparam logic [5:0] OpMtc1  = 6'b011001;
   localparam logic [5:0] OpAdds  = 6'b011010;
   localparam logic [5:0] OpSubs  = 6'b011011;
   localparam logic [5:0] OpCeqs  = 6'b011100;
   localparam logic [5:0] OpBc1t  = 6'b011101;
   localparam logic [5:0] OpHalt  = 6'b111111;

   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnOr  = 6'b100101;
   localparam logic [5:0] FnSlt = 6'b101010;

   // IEEE-754 single add/sub: align, add/sub 24-bit mantissas, normalise, truncate.
   // Denormals flush to signed zero, exponent overflow saturates to infinity.
   function automatic word_t fp_addsub(input word_t a, input word_t b, input logic sub);
      logic              s_a, s_b, s_l, s_s;
      logic [7:0]        e_a, e_b, e_l, e_s, diff;
      logic [23:0]       m_a, m_b, m_l, m_s, m_al;
      logic [24:0]       sum;
      logic [22:0]       mant;
      logic [4:0]        lz;
      logic              found;
      logic signed [9:0] e_r;
      word_t             res;
      s_a = a[31];
      s_b = b[31] ^ sub;
      e_a = a[30:23];
      e_b = b[30:23];
      m_a = (e_a == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
      m_b = (e_b == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
      if ({e_a, m_a} >= {e_b, m_b}) begin
         s_l = s_a; e_l = e_a; m_l = m_a;
         s_s = s_b; e_s = e_b; m_s = m_b;
      end else begin
         s_l = s_b; e_l = e_b; m_l = m_b;
         s_s = s_a; e_s = e_a; m_s = m_a;
      end
      diff = e_l - e_s;
      m_al = (diff > 8'd23) ? 24'd0 : (m_s >> diff);
      // The larger magnitude is first, so the subtraction never goes negative.
      sum  = (s_l == s_s) ? ({1'b0, m_l} + {1'b0, m_al}) : ({1'b0, m_l} - {1'b0, m_al});
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 23; i >= 0; i--) begin
         if (!found) begin
            if (sum[i]) found = 1'b1;
            else        lz    = lz + 5'd1;
         end
      end
      e_r = $signed({2'b00, e_l});
      if (sum[24]) begin
         mant = sum[23:1];
         e_r  = e_r + 10'sd1;
      end else begin
         // Shifting the bits below the leading one drops the hidden bit directly.
         mant = sum[22:0] << lz;
         e_r  = e_r - $signed({5'b00000, lz});
      end
      if (sum == 25'd0)          res = '0;
      else if (e_r >= 10'sd255)  res = {s_l, 8'hFF, 23'd0};
      else if (e_r <= 10'sd0)    res = {s_l, 31'd0};
      else                       res = {s_l, e_r[7:0], mant};
      return res;
   endfunction

   word_t imem_q [MEM_DEPTH];
   word_t dmem_q [MEM_DEPTH];

   logic [31:0][XLEN-1:0] int_rf_q, int_rf_d;
   logic [31:0][XLEN-1:0] fp_rf_q, fp_rf_d;
   logic [AW-1:0]         pc_q, pc_d;
   logic                  done_q, done_d;
   logic                  cc_q, cc_d;
   word_t                 out_q, out_d;

   logic [AW-1:0] PC_out;
   word_t         ins_out;
   logic [5:0]    op, funct;
   logic [4:0]    rs, rt, rd;
   word_t         imm_sext, rs_val, rt_val, fs_val, ft_val, dm_rdata, fp_res;
   logic [AW-1:0] mem_addr, pc_seq, pc_br;
   logic          fp_eq, exec_en, dm_we, int_we;
   logic [4:0]    int_waddr;
   word_t         int_wdata;

   assign PC_out   = pc_q;
   assign ins_out  = imem_q[PC_out];
   assign op       = ins_out[31:26];
   assign rs       = ins_out[25:21];
   assign rt       = ins_out[20:16];
   assign rd       = ins_out[15:11];
   assign funct    = ins_out[5:0];
   assign imm_sext = {{(XLEN-16){ins_out[15]}}, ins_out[15:0]};

   assign rs_val   = (rs == 5'd0) ? '0 : int_rf_q[rs];
   assign rt_val   = (rt == 5'd0) ? '0 : int_rf_q[rt];
   assign fs_val   = fp_rf_q[rs];
   assign ft_val   = fp_rf_q[rt];

   // Only the low address bits matter, so the address add is done at memory width.
   assign mem_addr = rs_val[AW-1:0] + imm_sext[AW-1:0];
   assign dm_rdata = dmem_q[mem_addr];
   assign pc_seq   = PC_out + PcOne;
   assign pc_br    = PC_out + PcOne + imm_sext[AW-1:0];

   // add.s and sub.s differ only in opcode bit 0.
   assign fp_res   = fp_addsub(fs_val, ft_val, op[0]);
   assign fp_eq    = (fs_val == ft_val) || ((fs_val[30:0] == 31'd0) && (ft_val[30:0] == 31'd0));

   // Loading either memory stalls the core.
   assign exec_en  = rst && !ins_we && !data_we && !done_q;

   // Decode and execute: next-state for PC, flags, register files and result bus.
   always_comb begin
      pc_d      = pc_q;
      done_d    = done_q;
      cc_d      = cc_q;
      out_d     = out_q;
      int_rf_d  = int_rf_q;
      fp_rf_d   = fp_rf_q;
      dm_we     = 1'b0;
      int_we    = 1'b0;
      int_waddr = 5'd0;
      int_wdata = '0;
      if (exec_en) begin
         pc_d = pc_seq;
         case (op)
            OpRtype: begin
               int_waddr = rd;
               int_we    = 1'b1;
               case (funct)
                  FnAdd:   int_wdata = rs_val + rt_val;
                  FnSub:   int_wdata = rs_val - rt_val;
                  FnAnd:   int_wdata = rs_val & rt_val;
                  FnOr:    int_wdata = rs_val | rt_val;
                  FnSlt:   int_wdata = {{(XLEN-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
                  default: int_we    = 1'b0;
               endcase
            end
            OpAddi: begin
               int_waddr = rt;
               int_wdata = rs_val + imm_sext;
               int_we    = 1'b1;
            end
            OpLw: begin
               int_waddr = rt;
               int_wdata = dm_rdata;
               int_we    = 1'b1;
            end
            OpSw:   dm_we = 1'b1;
            OpBeq:  if (rs_val == rt_val) pc_d = pc_br;
            OpJ:    pc_d = ins_out[AW-1:0];
            OpMfc1: begin
               int_waddr = rs;
               int_wdata = ft_val;
               int_we    = 1'b1;
            end
            OpMtc1: fp_rf_d[rt] = rs_val;
            OpAdds, OpSubs: fp_rf_d[rd] = fp_res;
            OpCeqs: cc_d = fp_eq;
            OpBc1t: if (cc_q) pc_d = pc_br;
            OpHalt: begin
               done_d = 1'b1;
               pc_d   = pc_q;
            end
            default: ;
         endcase
         if (int_we && (int_waddr != 5'd0)) begin
            int_rf_d[int_waddr] = int_wdata;
            out_d               = int_wdata;
         end
      end
   end

   // Architectural state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q     <= '0;
         done_q   <= 1'b0;
         cc_q     <= 1'b0;
         out_q    <= '0;
         int_rf_q <= '0;
         fp_rf_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         done_q   <= done_d;
         cc_q     <= cc_d;
         out_q    <= out_d;
         int_rf_q <= int_rf_d;
         fp_rf_q  <= fp_rf_d;
      end
   end

   // Memories are never cleared; external loads are accepted even during reset.
   always_ff @(posedge clk) begin
      if (ins_we) imem_q[instr_addr] <= instr;
      if (data_we)    dmem_q[data_addr] <= data;
      else if (dm_we) dmem_q[mem_addr]  <= rt_val;
   end

   assign processor_out = out_q;
   assign done          = done_q;

endmodule

// File: tb/tb_mips_processor_top.sv
module tb_mips_processor_top;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic [9:0]  instr_addr;
   logic        ins_we;
   logic [31:0] data;
   logic [9:0]  data_addr;
   logic        data_we;
   logic [31:0] processor_out;
   logic        done;

   int n_err = 0;
   int n_chk = 0;

   mips_processor_top dut (
      .clk           (clk),
      .rst           (rst),
      .instr         (instr),
      .instr_addr    (instr_addr),
      .ins_we        (ins_we),
      .data          (data),
      .data_addr     (data_addr),
      .data_we       (data_we),
      .processor_out (processor_out),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction-set reference model
   logic [31:0] m_imem [1024];
   logic [31:0] m_dmem [1024];
   logic [31:0] m_r [32];
   logic [31:0] m_f [32];
   logic [9:0]  m_pc;
   logic        m_cc, m_done;
   logic [31:0] m_out;

   logic [31:0] prog [$];
   logic [9:0]  pre_addr [$];
   logic [31:0] pre_data [$];

   function automatic real f2r(input logic [31:0] x);
      real v;
      int  e;
      if (x[30:23] == 8'd0) return 0.0;
      v = 1.0 + real'(x[22:0]) / 8388608.0;
      e = int'(x[30:23]) - 127;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return x[31] ? -v : v;
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic s;
      real  m;
      int   e, frac;
      if (r == 0.0) return 32'd0;
      s = (r < 0.0);
      m = s ? -r : r;
      e = 127;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0)   return {s, 31'd0};
      frac = $rtoi((m - 1.0) * 8388608.0);
      return {s, e[7:0], frac[22:0]};
   endfunction

   function automatic logic [31:0] f_i(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] f_r(input int fn, input int rs, input int rt, input int rd);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   localparam int HALT = 63;

   task automatic wr(input logic [4:0] idx, input logic [31:0] v);
      if (idx != 5'd0) begin
         m_r[idx] = v;
         m_out    = v;
      end
   endtask

   task automatic model_exec();
      logic [31:0] w, a, b, simm, ea, t;
      logic [4:0]  rs, rt, rd;
      logic [9:0]  nxt;
      w    = m_imem[m_pc];
      rs   = w[25:21];
      rt   = w[20:16];
      rd   = w[15:11];
      a    = m_r[rs];
      b    = m_r[rt];
      simm = {{16{w[15]}}, w[15:0]};
      ea   = a + simm;
      t    = {22'd0, m_pc} + 32'd1 + simm;
      nxt  = m_pc + 10'd1;
      case (int'(w[31:26]))
         0: case (int'(w[5:0]))
               32: wr(rd, a + b);
               34: wr(rd, a - b);
               36: wr(rd, a & b);
               37: wr(rd, a | b);
               42: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
               default: ;
            endcase
         8:  wr(rt, ea);
         35: wr(rt, m_dmem[ea[9:0]]);
         43: m_dmem[ea[9:0]] = b;
         4:  if (a == b) nxt = t[9:0];
         2:  nxt = w[9:0];
         24: wr(rs, m_f[rt]);
         25: m_f[rt] = a;
         26: m_f[rd] = r2f(f2r(m_f[rs]) + f2r(m_f[rt]));
         27: m_f[rd] = r2f(f2r(m_f[rs]) - f2r(m_f[rt]));
         28: m_cc = (m_f[rs] == m_f[rt]) ||
                    ((m_f[rs][30:0] == 31'd0) && (m_f[rt][30:0] == 31'd0));
         29: if (m_cc) nxt = t[9:0];
         63: begin m_done = 1'b1; nxt = m_pc; end
         default: ;
      endcase
      m_pc = nxt;
   endtask

   task automatic model_edge();
      if (ins_we)  m_imem[instr_addr] = instr;
      if (data_we) m_dmem[data_addr]  = data;
      if (!rst) begin
         m_pc = 10'd0; m_cc = 1'b0; m_done = 1'b0; m_out = 32'd0;
         for (int i = 0; i < 32; i++) begin m_r[i] = 32'd0; m_f[i] = 32'd0; end
      end else if (!ins_we && !data_we && !m_done) begin
         model_exec();
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_image();
      prog.delete();
      pre_addr.delete();
      pre_data.delete();
   endtask

   // Loads prog and the data preloads while held in reset, leaving rst low.
   task automatic load_image();
      rst = 1'b0;
      foreach (prog[i]) begin
         ins_we = 1'b1; instr_addr = 10'(i); instr = prog[i];
         tick();
      end
      ins_we = 1'b0;
      foreach (pre_addr[i]) begin
         data_we = 1'b1; data_addr = pre_addr[i]; data = pre_data[i];
         tick();
      end
      data_we = 1'b0;
      tick();
      tick();
   endtask

   task automatic run_to_halt(input int max_cycles);
      int used;
      used = 0;
      rst  = 1'b1;
      while (!m_done && used < max_cycles) begin
         tick();
         used++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; ins_we = 1'b0; data_we = 1'b0;
      instr = '0; instr_addr = '0; data = '0; data_addr = '0;
      #2;
      tick();
      tick();
      n_chk++; if (dut.PC_out !== 10'd0)
         begin n_err++; $display("FAIL reset_pc got=%0d want=0", dut.PC_out); end
      n_chk++; if (processor_out !== 32'd0)
         begin n_err++; $display("FAIL reset_out got=%h want=0", processor_out); end
      n_chk++; if (done !== 1'b0)
         begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
   endtask

   task automatic test_move_halt();
      clear_image();
      prog = '{f_i(8, 0, 2, 5), f_i(25, 2, 4, 0), f_i(24, 3, 4, 0), f_i(HALT, 0, 0, 0)};
      load_image();
      rst = 1'b1;
      tick();
      n_chk++; if (processor_out !== 32'd5)
         begin n_err++; $display("FAIL addi_out got=%h want=5", processor_out); end
      n_chk++; if (dut.PC_out !== 10'd1)
         begin n_err++; $display("FAIL addi_pc got=%0d want=1", dut.PC_out); end
      tick();
      tick();
      n_chk++; if (dut.int_rf_q[3] !== 32'd5)
         begin n_err++; $display("FAIL mfc1_r3 got=%h want=5", dut.int_rf_q[3]); end
      n_chk++; if (done !== 1'b0)
         begin n_err++; $display("FAIL early_done got=%b want=0", done); end
      tick();
      tick();
      n_chk++; if (done !== 1'b1)
         begin n_err++; $display("FAIL halt_done got=%b want=1", done); end
      n_chk++; if (dut.PC_out !== 10'd3)
         begin n_err++; $display("FAIL halt_pc got=%0d want=3", dut.PC_out); end
      n_chk++; if (processor_out !== 32'd5)
         begin n_err++; $display("FAIL halt_out got=%h want=5", processor_out); end
   endtask

   task automatic fp_program(input logic [31:0] a, input logic [31:0] b);
      clear_image();
      pre_addr = '{10'd0, 10'd1};
      pre_data = '{a, b};
      prog = '{f_i(35, 0, 1, 0), f_i(35, 0, 2, 1), f_i(25, 1, 4, 0), f_i(25, 2, 5, 0),
               f_i(26, 4, 5, 6 * 2048), f_i(27, 4, 5, 7 * 2048),
               f_i(24, 3, 6, 0), f_i(24, 4, 7, 0), f_i(HALT, 0, 0, 0)};
      load_image();
      run_to_halt(40);
   endtask

   task automatic test_fp_arith();
      logic [31:0] a, b, e_sum, e_diff;
      fp_program(32'h3FC00000, 32'h40100000);
      n_chk++; if (dut.int_rf_q[3] !== 32'h40700000)
         begin n_err++; $display("FAIL fp_add got=%h want=40700000", dut.int_rf_q[3]); end
      n_chk++; if (processor_out !== 32'hBF400000)
         begin n_err++; $display("FAIL fp_sub got=%h want=bf400000", processor_out); end
      // Operands with few mantissa bits and close exponents give exact results.
      for (int k = 0; k < 6; k++) begin
         a = {1'($urandom), 8'($urandom_range(120, 130)), 8'($urandom_range(0, 255)), 15'd0};
         b = {1'($urandom), 8'($urandom_range(120, 130)), 8'($urandom_range(0, 255)), 15'd0};
         if (k == 5) b = a;
         e_sum  = r2f(f2r(a) + f2r(b));
         e_diff = r2f(f2r(a) - f2r(b));
         fp_program(a, b);
         n_chk++; if (dut.int_rf_q[3] !== e_sum)
            begin n_err++; $display("FAIL fp_add_rand a=%h b=%h got=%h want=%h",
                                    a, b, dut.int_rf_q[3], e_sum); end
         n_chk++; if (dut.int_rf_q[4] !== e_diff)
            begin n_err++; $display("FAIL fp_sub_rand a=%h b=%h got=%h want=%h",
                                    a, b, dut.int_rf_q[4], e_diff); end
      end
   endtask

   task automatic test_fp_compare_branch();
      clear_image();
      pre_addr = '{10'd0, 10'd1, 10'd2, 10'd3};
      pre_data = '{32'h3FC00000, 32'h40100000, 32'h00000000, 32'h80000000};
      prog = '{f_i(35, 0, 1, 0), f_i(35, 0, 2, 1), f_i(25, 1, 4, 0), f_i(25, 2, 5, 0),
               f_i(28, 4, 5, 0), f_i(29, 0, 0, 2), f_i(8, 0, 5, 1),
               f_i(35, 0, 1, 2), f_i(35, 0, 2, 3), f_i(25, 1, 8, 0), f_i(25, 2, 9, 0),
               f_i(28, 8, 9, 0), f_i(29, 0, 0, 1), f_i(8, 0, 6, 7), f_i(8, 0, 7, 9),
               f_i(HALT, 0, 0, 0)};
      load_image();
      rst = 1'b1;
      repeat (5) tick();
      n_chk++; if (dut.cc_q !== 1'b0)
         begin n_err++; $display("FAIL ceq_ne got=%b want=0", dut.cc_q); end
      run_to_halt(40);
      n_chk++; if (dut.int_rf_q[5] !== 32'd1)
         begin n_err++; $display("FAIL bc1t_not_taken got=%h want=1", dut.int_rf_q[5]); end
      n_chk++; if (dut.cc_q !== 1'b1)
         begin n_err++; $display("FAIL ceq_zero got=%b want=1", dut.cc_q); end
      n_chk++; if (dut.int_rf_q[6] !== 32'd0)
         begin n_err++; $display("FAIL bc1t_taken got=%h want=0", dut.int_rf_q[6]); end
      n_chk++; if (processor_out !== 32'd9)
         begin n_err++; $display("FAIL bc1t_target got=%h want=9", processor_out); end
   endtask

   task automatic test_load_store();
      clear_image();
      pre_addr = '{10'd7};
      pre_data = '{32'hDEADBEEF};
      prog = '{f_i(35, 0, 4, 7), f_i(8, 0, 5, 100), f_i(43, 5, 4, 3), f_i(35, 0, 6, 103),
               f_i(HALT, 0, 0, 0)};
      load_image();
      rst = 1'b1;
      tick();
      n_chk++; if (processor_out !== 32'hDEADBEEF)
         begin n_err++; $display("FAIL lw_out got=%h want=deadbeef", processor_out); end
      run_to_halt(20);
      n_chk++; if (dut.dmem_q[103] !== 32'hDEADBEEF)
         begin n_err++; $display("FAIL sw_mem got=%h want=deadbeef", dut.dmem_q[103]); end
      n_chk++; if (dut.int_rf_q[6] !== 32'hDEADBEEF)
         begin n_err++; $display("FAIL sw_lw got=%h want=deadbeef", dut.int_rf_q[6]); end
   endtask

   task automatic test_random_int();
      int fn_tab [5] = '{32, 34, 36, 37, 42};
      int len, im;
      for (int p = 0; p < 4; p++) begin
         clear_image();
         for (int i = 0; i < 8; i++) begin
            pre_addr.push_back(10'(i));
            pre_data.push_back($urandom);
         end
         len = 24;
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 9))
               0, 1: prog.push_back(f_i(8, $urandom_range(0, 7), $urandom_range(0, 7),
                                        $urandom_range(0, 65535)));
               2, 3, 4, 5: prog.push_back(f_r(fn_tab[$urandom_range(0, 4)], $urandom_range(0, 7),
                                              $urandom_range(0, 7), $urandom_range(0, 7)));
               6: prog.push_back(f_i(35, 0, $urandom_range(0, 7), $urandom_range(0, 7)));
               7: prog.push_back(f_i(43, 0, $urandom_range(0, 7), $urandom_range(0, 7)));
               8: begin
                  im = $urandom_range(0, 2);
                  if (im > len - 1 - i) im = len - 1 - i;
                  prog.push_back(f_i(4, $urandom_range(0, 7), $urandom_range(0, 7), im));
               end
               default: prog.push_back(f_r(1, $urandom_range(0, 7), $urandom_range(0, 7),
                                           $urandom_range(1, 7)));
            endcase
         end
         prog.push_back(f_i(HALT, 0, 0, 0));
         load_image();
         rst = 1'b1;
         for (int c = 0; c < 100 && !m_done; c++) begin
            tick();
            n_chk++; if (processor_out !== m_out)
               begin n_err++; $display("FAIL rand_out prog=%0d cyc=%0d got=%h want=%h",
                                       p, c, processor_out, m_out); end
            n_chk++; if (dut.PC_out !== m_pc)
               begin n_err++; $display("FAIL rand_pc prog=%0d cyc=%0d got=%0d want=%0d",
                                       p, c, dut.PC_out, m_pc); end
         end
         n_chk++; if (done !== 1'b1)
            begin n_err++; $display("FAIL rand_done prog=%0d got=%b want=1", p, done); end
      end
   endtask

   task automatic test_stall_restart();
      clear_image();
      prog = '{f_i(8, 0, 1, 1), f_i(8, 1, 1, 1), {6'd2, 26'd4}, f_i(8, 1, 1, 100),
               f_i(8, 1, 1, 1), f_i(HALT, 0, 0, 0)};
      load_image();
      rst = 1'b1;
      tick();
      ins_we = 1'b1; instr_addr = 10'd900; instr = 32'h12345678;
      tick();
      tick();
      ins_we = 1'b0;
      data_we = 1'b1; data_addr = 10'd900; data = 32'h0;
      tick();
      data_we = 1'b0;
      n_chk++; if (dut.PC_out !== 10'd1)
         begin n_err++; $display("FAIL stall_pc got=%0d want=1", dut.PC_out); end
      n_chk++; if (processor_out !== 32'd1)
         begin n_err++; $display("FAIL stall_out got=%h want=1", processor_out); end
      run_to_halt(20);
      n_chk++; if (processor_out !== 32'd3)
         begin n_err++; $display("FAIL jump_out got=%h want=3", processor_out); end
      n_chk++; if (done !== 1'b1)
         begin n_err++; $display("FAIL stall_done got=%b want=1", done); end
      rst = 1'b0;
      tick();
      n_chk++; if (done !== 1'b0)
         begin n_err++; $display("FAIL rerst_done got=%b want=0", done); end
      n_chk++; if (dut.PC_out !== 10'd0)
         begin n_err++; $display("FAIL rerst_pc got=%0d want=0", dut.PC_out); end
      n_chk++; if (processor_out !== 32'd0)
         begin n_err++; $display("FAIL rerst_out got=%h want=0", processor_out); end
      n_chk++; if (dut.int_rf_q[1] !== 32'd0)
         begin n_err++; $display("FAIL rerst_reg got=%h want=0", dut.int_rf_q[1]); end
      run_to_halt(20);
      n_chk++; if (processor_out !== 32'd3)
         begin n_err++; $display("FAIL rerun_out got=%h want=3", processor_out); end
      n_chk++; if (done !== 1'b1)
         begin n_err++; $display("FAIL rerun_done got=%b want=1", done); end
   endtask

   initial begin
      test_reset();
      test_move_halt();
      test_fp_arith();
      test_fp_compare_branch();
      test_load_store();
      test_random_int();
      test_stall_restart();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
